// File: rtl/weight_mem_loader.sv
// Run-time write sequencer for one neuron's weight memory: filters a tagged
// weight stream and writes matching words to consecutive addresses.
module weight_mem_loader #(
  parameter int numWeight    = 3,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int layerNo      = 0,
  parameter int neuronNo     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [dataWidth-1:0]    s_data,
  input  logic [7:0]              s_layer,
  input  logic [7:0]              s_neuron,
  output logic                    wen,
  output logic [addressWidth-1:0] wadd,
  output logic [dataWidth-1:0]    win,
  output logic                    busy,
  output logic                    done,
  output logic [addressWidth:0]   loaded
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOAD = 1'b1;

  localparam logic [7:0]            LAYER_TAG  = 8'(layerNo);
  localparam logic [7:0]            NEURON_TAG = 8'(neuronNo);
  localparam logic [addressWidth:0] LAST_CNT   = (addressWidth+1)'(numWeight - 1);

  logic [0:0] state;
  logic       accept;
  logic       tag_hit;
  logic       wr_hit;
  logic       last_word;

  // Ready depends on state alone so the upstream never sees a valid->ready path.
  assign s_ready   = (state == LOAD);
  assign busy      = (state == LOAD);
  assign accept    = s_valid && s_ready;
  assign tag_hit   = (s_layer == LAYER_TAG) && (s_neuron == NEURON_TAG);
  assign wr_hit    = accept && tag_hit && !abort;
  assign last_word = (loaded == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wen    <= 1'b0;
      wadd   <= '0;
      win    <= '0;
      done   <= 1'b0;
      loaded <= '0;
    end else begin
      wen  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state  <= LOAD;
            loaded <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            // Any word handshaking alongside abort is consumed but discarded.
            state <= IDLE;
          end else if (wr_hit) begin
            wen    <= 1'b1;
            wadd   <= loaded[addressWidth-1:0];
            win    <= s_data;
            loaded <= loaded + 1'b1;
            if (last_word) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/weight_mem_loader.md
Name: weight_mem_loader

Overview:
- Write-side sequencer for the per-neuron weight memory. It fills that memory at run time instead of relying only on the power-up file image.
- Accepts a tagged weight stream over a valid/ready handshake and keeps only words whose layer/neuron tag matches this neuron.
- Drives sequential write address/data/enable to the memory's write port and signals completion.
- One instance per neuron, placed between the global configuration stream and that neuron's weight memory.

Parameters:
- numWeight, 3, number of weights to load (1 ≤ numWeight ≤ 2^addressWidth).
- addressWidth, 10, write address width.
- dataWidth, 16, weight word width.
- layerNo, 0, layer tag this instance accepts (8-bit compare).
- neuronNo, 0, neuron tag this instance accepts (8-bit compare).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- abort  in  1  cancels an in-progress load.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream word ready.
- s_data  in  dataWidth  weight word.
- s_layer  in  8  layer tag of the word.
- s_neuron  in  8  neuron tag of the word.
- wen  out  1  memory write enable, registered.
- wadd  out  addressWidth  memory write address, registered.
- win  out  dataWidth  memory write data, registered.
- busy  out  1  high while in LOAD.
- done  out  1  one-cycle pulse when the last weight is written.
- loaded  out  addressWidth+1  number of weights written in the current or last load.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; wen=0, wadd=0, win=0, busy=0, done=0, loaded=0. rst has priority over all other inputs.
- States: IDLE, LOAD.
- IDLE:
  - s_ready=0.
  - start=1 → LOAD next cycle; loaded cleared to 0 on the same edge; busy=1 from the next cycle.
- LOAD:
  - s_ready=1, combinational from state only; it never depends on s_valid.
  - A word is accepted when s_valid && s_ready.
  - Tag match: accepted word with s_layer==layerNo and s_neuron==neuronNo. The cycle after acceptance, wen=1, wadd=loaded[addressWidth-1:0] (pre-increment value), win=s_data, and loaded increments by 1.
  - Tag mismatch: word is still accepted (consumed), but is dropped. No write, no count change.
  - Registered latency of 1 cycle from accept to write. Back-to-back accepts give back-to-back writes at consecutive addresses 0,1,2,…
  - wen is 0 in every cycle without a matching accept in the previous cycle. wadd and win hold their last values when wen=0.
- Completion: on accepting the matching word while loaded==numWeight-1:
  - next cycle wen=1 (last address numWeight-1), done=1, busy=0, state=IDLE;
  - done is low the following cycle; loaded holds numWeight until the next start.
- No words are accepted after completion, because s_ready=0 in IDLE.
- start while in LOAD is ignored; it does not restart the counter.
- abort=1 in LOAD:
  - state→IDLE next cycle, busy=0, no done.
  - A word handshaking in the same cycle as abort is still accepted (s_ready is state-based) but is NOT written; wen=0 the next cycle.
  - loaded keeps its partial count.
- abort in IDLE has no effect. start and abort together in IDLE: abort wins and the state stays IDLE.
- numWeight=1: the first matching word completes the load; write to address 0 and done occur in the same cycle.
- Address never wraps, since the load ends at numWeight-1. loaded is addressWidth+1 bits so it can represent 2^addressWidth.

Test Plan:
- Basic load, numWeight=3, tags match: start, then three back-to-back words 0x0011, 0x0022, 0x0033. Expect wen on three consecutive cycles with wadd=0,1,2 and win equal to those words; done pulses with the address-2 write; busy falls in that same cycle; loaded=3; s_ready=0 afterwards.
- Tag filtering: during LOAD, send a word with s_neuron=neuronNo+1 (value 0xBEEF) between matching words 0x0001 and 0x0002. Expect the 0xBEEF word consumed (s_ready=1) with no wen for it; writes 0x0001→addr 0, 0x0002→addr 1; loaded counts only matching words.
- Gapped stream: s_valid toggled 1,0,0,1,0,1. Expect wen only on the cycles after accepts, addresses contiguous 0,1,2, done on the last write.
- Abort mid-load: after one write, assert abort with a valid word 0x0055 present. Expect that word not written, busy=0 next cycle, no done, loaded=1. A subsequent start clears loaded and writes from addr 0 again.
- Reset mid-load: rst during LOAD after 2 writes. Expect all outputs 0 next cycle and s_ready=0; start is ignored while rst=1.
- Start ignored in LOAD, plus the numWeight=1 build: a second start mid-load does not reset addresses. With numWeight=1, a single word 0x7FFF gives wen, wadd=0 and done in the same cycle.
